// File: rtl/gcd_run_ctrl_if.sv
// gcd_run_ctrl_if
//   Valid/ready link between the run sequencer and the GCD core.
//   master : sequencer side (drives request, accepts response)
//   slave  : core side (accepts request, drives response)
//   Signals:
//     req_val / req_rdy / req_msg[2W-1:0]  request {a,b}, a in the upper W bits
//     resp_val / resp_rdy / resp_msg[W-1:0] response (GCD result)
interface gcd_run_ctrl_if #(
  parameter int unsigned W = 16
);
  logic           req_val;
  logic           req_rdy;
  logic [2*W-1:0] req_msg;
  logic           resp_val;
  logic           resp_rdy;
  logic [W-1:0]   resp_msg;

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );
endinterface

// File: rtl/gcd_run_ctrl.sv
// gcd_run_ctrl
//   Sequencer between the APB register file and the GCD core. Accepts a
//   start pulse with two operands, issues one request to the core, waits
//   for the response, captures the result and counts the run cycles.
//   Operands with a zero are answered locally (result = op_a | op_b).
//
//   Optional watchdog: define GCD_CTRL_TIMEOUT_EN to abort a run once
//   cycle_count reaches TIMEOUT; otherwise timeout_err is tied to 0.
//
//   Ports:
//     CLK, RESET            clock, asynchronous active-high reset
//     start                 single-cycle start pulse
//     op_a, op_b [W]        operands, sampled on an accepted start
//     irq_en                interrupt enable at completion
//     irq_clr               write-1-to-clear pulse for irq_status/timeout_err
//     core                  request/response link to the GCD core (master)
//     result [W]            last result
//     run_status            job in progress
//     irq_status            sticky completion interrupt
//     cycle_count [32]      cycles spent in the last or current run
//     timeout_err           sticky watchdog abort flag
module gcd_run_ctrl #(
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [W-1:0]          op_a,
  input  logic [W-1:0]          op_b,
  input  logic                  irq_en,
  input  logic                  irq_clr,
  gcd_run_ctrl_if.master        core,
  output logic [W-1:0]          result,
  output logic                  run_status,
  output logic                  irq_status,
  output logic [31:0]           cycle_count,
  output logic                  timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("gcd_run_ctrl: TIMEOUT must be at least 1");
  end

  logic [1:0]     state_q,    state_d;
  logic           req_val_q,  req_val_d;
  logic           resp_rdy_q, resp_rdy_d;
  logic [2*W-1:0] req_msg_q,  req_msg_d;
  logic [W-1:0]   result_q,   result_d;
  logic           run_q,      run_d;
  logic           irq_q,      irq_d;
  logic [31:0]    cnt_q,      cnt_d;
  logic           tmo_q,      tmo_d;

  logic        busy;
  logic        req_hs;
  logic        resp_hs;
  logic        irq_set;
  logic        tmo_set;
  logic [31:0] cnt_inc;

  always_comb begin
    state_d    = state_q;
    req_val_d  = req_val_q;
    resp_rdy_d = resp_rdy_q;
    req_msg_d  = req_msg_q;
    result_d   = result_q;
    run_d      = run_q;
    cnt_d      = cnt_q;
    irq_set    = 1'b0;
    tmo_set    = 1'b0;

    busy    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    req_hs  = (state_q == S_ISSUE) && req_val_q && core.req_rdy;
    resp_hs = (state_q == S_WAIT) && resp_rdy_q && core.resp_val;
    // Saturating increment: the counter must never wrap back to zero.
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if ((op_a != '0) && (op_b != '0)) begin
            req_msg_d = {op_a, op_b};
            run_d     = 1'b1;
            req_val_d = 1'b1;
            state_d   = S_ISSUE;
          end else begin
            // gcd(x,0) = x, and gcd(0,0) is reported as 0.
            result_d = op_a | op_b;
            irq_set  = irq_en;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_inc;
        if (req_hs) begin
          req_val_d  = 1'b0;
          resp_rdy_d = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (resp_hs) begin
          result_d   = core.resp_msg;
          run_d      = 1'b0;
          resp_rdy_d = 1'b0;
          irq_set    = irq_en;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        req_val_d  = 1'b0;
        resp_rdy_d = 1'b0;
        run_d      = 1'b0;
      end
    endcase

`ifdef GCD_CTRL_TIMEOUT_EN
    // Abort on the edge where the count reaches TIMEOUT; a response
    // arriving in that same cycle is a normal completion instead.
    if (busy && !resp_hs && (cnt_inc >= 32'(TIMEOUT))) begin
      state_d    = S_IDLE;
      req_val_d  = 1'b0;
      resp_rdy_d = 1'b0;
      run_d      = 1'b0;
      tmo_set    = 1'b1;
      irq_set    = irq_en;
    end
`endif

    // Set takes priority over a coinciding clear.
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if (irq_set) irq_d = 1'b1;

    tmo_d = tmo_q;
    if (irq_clr) tmo_d = 1'b0;
    if (tmo_set) tmo_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      req_val_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
      req_msg_q  <= '0;
      result_q   <= '0;
      run_q      <= 1'b0;
      irq_q      <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_val_q  <= req_val_d;
      resp_rdy_q <= resp_rdy_d;
      req_msg_q  <= req_msg_d;
      result_q   <= result_d;
      run_q      <= run_d;
      irq_q      <= irq_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign core.req_val  = req_val_q;
  assign core.req_msg  = req_msg_q;
  assign core.resp_rdy = resp_rdy_q;
  assign result        = result_q;
  assign run_status    = run_q;
  assign irq_status    = irq_q;
  assign cycle_count   = cnt_q;
  assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_gcd_run_ctrl.sv
// tb_gcd_run_ctrl
//   Directed and randomized jobs against gcd_run_ctrl. The bench plays the
//   GCD core itself and predicts results with a plain Euclid reference,
//   cycle counts from the number of cycles it held each phase, and the
//   sticky flags from the set/clear rules.
module tb_gcd_run_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        irq_en;
  logic        irq_clr;
  logic [15:0] result;
  logic        run_status;
  logic        irq_status;
  logic [31:0] cycle_count;
  logic        timeout_err;

  gcd_run_ctrl_if #(.W(16)) core_if ();

  gcd_run_ctrl #(.W(16), .TIMEOUT(16)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .irq_en      (irq_en),
    .irq_clr     (irq_clr),
    .core        (core_if),
    .result      (result),
    .run_status  (run_status),
    .irq_status  (irq_status),
    .cycle_count (cycle_count),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned req_hs_n = 0;
  logic [15:0] exp_result = '0;
  logic        exp_irq    = 1'b0;
  logic        exp_tmo    = 1'b0;

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    int unsigned x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 16'(x);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Inputs are set at a negedge; the request handshake is recorded just
  // after that, then time advances to the next negedge.
  task automatic step();
    #1;
    if (core_if.req_val === 1'b1 && core_if.req_rdy === 1'b1) req_hs_n++;
    @(negedge CLK);
  endtask

  task automatic do_clr();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    exp_irq = 1'b0;
    exp_tmo = 1'b0;
    chk("clr_irq", irq_status, exp_irq);
    chk("clr_tmo", timeout_err, exp_tmo);
  endtask

  // One job: rd cycles of ISSUE before req_rdy, sd WAIT cycles before the
  // response, optional irq_clr on the completion cycle, optional stray
  // start (7,5) while the job is in WAIT.
  task automatic run_job(input logic [15:0] a, input logic [15:0] b,
                         input int unsigned rd, input int unsigned sd,
                         input logic en, input logic clr, input logic stray);
    int unsigned hs0;
    logic [15:0] g;
    g   = ref_gcd(a, b);
    hs0 = req_hs_n;
    op_a   = a;
    op_b   = b;
    irq_en = en;
    start  = 1'b1;
    if (a == 0 || b == 0) begin
      irq_clr = clr;
      step();
      start   = 1'b0;
      irq_clr = 1'b0;
      exp_result = g;
      if (clr) exp_tmo = 1'b0;
      exp_irq = en ? 1'b1 : (clr ? 1'b0 : exp_irq);
      chk("byp_result", result, exp_result);
      chk("byp_count", cycle_count, 32'd0);
      chk("byp_run", run_status, 1'b0);
      chk("byp_irq", irq_status, exp_irq);
      chk("byp_reqval", core_if.req_val, 1'b0);
      chk("byp_hs", req_hs_n, hs0);
      return;
    end
    step();
    start = 1'b0;
    chk("iss_run", run_status, 1'b1);
    chk("iss_reqval", core_if.req_val, 1'b1);
    chk("iss_msg", core_if.req_msg, {a, b});
    chk("iss_count", cycle_count, 32'd0);
    for (int i = 0; i < int'(rd); i++) begin
      core_if.resp_val = (i % 2 == 0);
      core_if.resp_msg = 16'hBEEF;
      step();
      chk("iss_hold_val", core_if.req_val, 1'b1);
      chk("iss_hold_rdy", core_if.resp_rdy, 1'b0);
    end
    core_if.resp_val = 1'b0;
    core_if.req_rdy  = 1'b1;
    step();
    core_if.req_rdy = 1'b0;
    chk("wait_resprdy", core_if.resp_rdy, 1'b1);
    chk("wait_reqval", core_if.req_val, 1'b0);
    if (stray) begin
      start = 1'b1;
      op_a  = 16'd7;
      op_b  = 16'd5;
    end
    for (int i = 0; i < int'(sd); i++) begin
      step();
      start = 1'b0;
      chk("wait_run", run_status, 1'b1);
    end
    core_if.resp_val = 1'b1;
    core_if.resp_msg = g;
    irq_clr = clr;
    step();
    start = 1'b0;
    core_if.resp_val = 1'b0;
    irq_clr = 1'b0;
    exp_result = g;
    if (clr) exp_tmo = 1'b0;
    exp_irq = en ? 1'b1 : (clr ? 1'b0 : exp_irq);
    chk("done_result", result, exp_result);
    chk("done_count", cycle_count, 32'(rd + sd + 2));
    chk("done_run", run_status, 1'b0);
    chk("done_irq", irq_status, exp_irq);
    chk("done_tmo", timeout_err, exp_tmo);
    chk("done_resprdy", core_if.resp_rdy, 1'b0);
    chk("done_msg", core_if.req_msg, {a, b});
    chk("done_hs", req_hs_n, hs0 + 1);
  endtask

  initial begin
    RESET   = 1'b1;
    start   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    irq_en  = 1'b0;
    irq_clr = 1'b0;
    core_if.req_rdy  = 1'b0;
    core_if.resp_val = 1'b0;
    core_if.resp_msg = '0;
    #3;
    chk("rst_reqval", core_if.req_val, 1'b0);
    chk("rst_resprdy", core_if.resp_rdy, 1'b0);
    chk("rst_msg", core_if.req_msg, 32'd0);
    chk("rst_result", result, 16'd0);
    chk("rst_run", run_status, 1'b0);
    chk("rst_irq", irq_status, 1'b0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_tmo", timeout_err, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // 48/18, ready at once, response on the 5th WAIT cycle.
    run_job(16'd48, 16'd18, 0, 4, 1'b1, 1'b0, 1'b0);
    do_clr();

    // Zero bypass, then clear.
    run_job(16'd0, 16'd35, 0, 0, 1'b1, 1'b0, 1'b0);
    do_clr();

    // Stray start while waiting on a 12/8 job.
    run_job(16'd12, 16'd8, 1, 3, 1'b1, 1'b0, 1'b1);
    do_clr();

    // Clear coinciding with completion: set wins.
    run_job(16'd20, 16'd15, 0, 1, 1'b1, 1'b1, 1'b0);
    // irq_en low must not clear a pending irq.
    irq_en = 1'b0;
    step();
    chk("irqen_hold", irq_status, exp_irq);
    do_clr();
    // irq_en low at completion: no irq, result still updates.
    run_job(16'd21, 16'd14, 2, 0, 1'b0, 1'b0, 1'b0);
    // gcd(0,0) through the bypass.
    run_job(16'd0, 16'd0, 0, 0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of WAIT.
    op_a = 16'd100; op_b = 16'd75; irq_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    core_if.req_rdy = 1'b1;
    step();
    core_if.req_rdy = 1'b0;
    step();
    #2 RESET = 1'b1;
    #1;
    chk("mrst_resprdy", core_if.resp_rdy, 1'b0);
    chk("mrst_run", run_status, 1'b0);
    chk("mrst_result", result, 16'd0);
    chk("mrst_irq", irq_status, 1'b0);
    chk("mrst_count", cycle_count, 32'd0);
    chk("mrst_msg", core_if.req_msg, 32'd0);
    exp_result = '0;
    exp_irq    = 1'b0;
    exp_tmo    = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    run_job(16'd9, 16'd6, 0, 2, 1'b1, 1'b0, 1'b0);

    // Randomized back-to-back jobs.
    for (int j = 0; j < 25; j++) begin
      logic [15:0] ra, rb;
      int unsigned k;
      k  = $urandom_range(1, 9);
      ra = 16'($urandom_range(0, 400) * k);
      rb = 16'($urandom_range(0, 400) * k);
      if ($urandom_range(0, 5) == 0) ra = '0;
      if ($urandom_range(0, 5) == 0) rb = '0;
      run_job(ra, rb, $urandom_range(0, 3), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

`ifdef GCD_CTRL_TIMEOUT_EN
    // Core accepts the request but never responds.
    do_clr();
    op_a = 16'd30; op_b = 16'd42; irq_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    core_if.req_rdy = 1'b1;
    step();
    core_if.req_rdy = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("tmo_pre_run", run_status, 1'b1);
    chk("tmo_pre_count", cycle_count, 32'd15);
    step();
    exp_irq = 1'b1;
    exp_tmo = 1'b1;
    chk("tmo_count", cycle_count, 32'd16);
    chk("tmo_err", timeout_err, exp_tmo);
    chk("tmo_run", run_status, 1'b0);
    chk("tmo_irq", irq_status, exp_irq);
    chk("tmo_result", result, exp_result);
    chk("tmo_resprdy", core_if.resp_rdy, 1'b0);
    chk("tmo_reqval", core_if.req_val, 1'b0);
    do_clr();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_run_ctrl.md
Name: gcd_run_ctrl

Overview:
Sequencer between the APB register file and the GCD core.
- Takes a start pulse plus two operands from CTRL and runs one job over the core's valid/ready request and response interfaces.
- Captures the result and counts run cycles.
- Drives the RUN_STATUS, IRQ_STATUS and CYCLE_COUNT values shown in the register map.

Parameters:
W, 16, operand and result width
TIMEOUT, 1024, watchdog limit in cycles; used only with GCD_CTRL_TIMEOUT_EN

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous reset, active-high
start  in  1  single-cycle start pulse from the register file
op_a  in  W  operand A, sampled on an accepted start
op_b  in  W  operand B, sampled on an accepted start
irq_en  in  1  interrupt enable
irq_clr  in  1  clears irq_status (write-1-to-clear pulse)
req_val  out  1  request valid to the GCD core
req_rdy  in  1  core ready to accept a request
req_msg  out  2W  request message, {a,b} with a in the upper W bits
resp_val  in  1  core response valid
resp_rdy  out  1  ready for a core response
resp_msg  in  W  core result
result  out  W  last result, held until the next completion
run_status  out  1  job in progress
irq_status  out  1  sticky completion interrupt
cycle_count  out  32  cycles spent in the last or current run
timeout_err  out  1  sticky watchdog abort flag

Behaviour:
- Reset (asynchronous, RESET=1):
  - State goes to IDLE.
  - Every output is 0: req_val, resp_rdy, req_msg, result, run_status, irq_status, cycle_count, timeout_err.
  - Reset during ISSUE or WAIT abandons the job immediately. No result or irq is produced.
- State machine: IDLE, ISSUE, WAIT. All state, outputs and counters are registered.
- IDLE:
  - req_val=0, resp_rdy=0.
  - start=1 with op_a!=0 and op_b!=0: latch {op_a,op_b} into req_msg, set cycle_count=0, set run_status=1, go to ISSUE.
  - start=1 with op_a==0 or op_b==0 (zero bypass): the core is not used. Next cycle result=op_a|op_b (so gcd(0,0)=0), cycle_count=0, irq_status set if irq_en=1, run_status stays 0, state stays IDLE.
- ISSUE:
  - req_val=1 and req_msg held stable until the handshake.
  - req_val && req_rdy: go to WAIT.
- WAIT:
  - resp_rdy=1.
  - resp_val && resp_rdy: result<=resp_msg, run_status<=0, irq_status<=1 if irq_en=1, go to IDLE.
  - A resp_val seen in ISSUE is ignored, because resp_rdy=0 there.
- cycle_count:
  - Increments by 1 every cycle the FSM is in ISSUE or WAIT, including the cycle of the response handshake.
  - Saturates at 32'hFFFFFFFF; never wraps.
  - Holds its value in IDLE until the next accepted start.
- start while run_status=1: ignored; op_a and op_b are not sampled.
- irq_clr:
  - Clears irq_status the next cycle.
  - If irq_clr coincides with a completion that sets irq_status, the set wins.
- irq_en=0 at completion: irq_status is not set. Deasserting irq_en does not clear an irq_status that is already pending.
- Latency, back-to-back: start accepted at cycle t. With req_rdy=1 at t+1 and resp_val at t+1+N, run_status drops and result is valid at t+2+N. A new start is accepted in that same cycle.

Optional Feature:
GCD_CTRL_TIMEOUT_EN
- Defined: if cycle_count reaches TIMEOUT while in ISSUE or WAIT, the run aborts.
  - Next cycle: state=IDLE, req_val=0, resp_rdy=0, run_status=0, timeout_err=1 (sticky).
  - irq_status is set if irq_en=1; result is unchanged.
  - timeout_err clears only on irq_clr or RESET.
  - A response in the same cycle as the timeout wins: it is a normal completion and timeout_err is not set.
- Undefined: no watchdog; timeout_err is tied to 0 and TIMEOUT is unused.

Test Plan:
- op_a=48, op_b=18, start; core model asserts req_rdy on the first ISSUE cycle and returns resp_msg=6 on the 5th WAIT cycle -> result=6, cycle_count=6, run_status 1 then 0, irq_status=1 (irq_en=1).
- op_a=0, op_b=35, start -> no req_val; result=35 next cycle, cycle_count=0, irq_status=1; then irq_clr -> irq_status=0.
- Start pulse while WAIT (operands 7,5) during a 12/8 job -> ignored; result=4, req_msg stays {12,8}, exactly one request handshake.
- irq_clr in the same cycle as completion -> irq_status=1; with irq_en=0 -> irq_status stays 0 and result still updates.
- RESET asserted mid-WAIT -> all outputs 0 asynchronously; after release, a new job 9/6 returns result=3.
- GCD_CTRL_TIMEOUT_EN defined, TIMEOUT=16, core never responds -> abort with cycle_count=16, timeout_err=1, run_status=0, irq_status=1, result unchanged.
